// File: rtl/afu_tlx_arb_pkg.sv
// Shared constants, state type and beat helper for the AFU->TLX command arbiter.
// Optional stats outputs are enabled in the top by AFU_TLX_ARB_STATS_EN.
package afu_tlx_arb_pkg;

    localparam logic [7:0] WRITE_MEM    = 8'h20;
    localparam logic [7:0] WRITE_MEM_BE = 8'h28;

    localparam logic [1:0] DL_RSVD = 2'b00;
    localparam logic [1:0] DL_64B  = 2'b01;
    localparam logic [1:0] DL_128B = 2'b10;
    localparam logic [1:0] DL_256B = 2'b11;

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        ARB        = 2'd1,
        DATA       = 2'd2
    } arb_state_e;

    // Number of 64B cdata beats that follow a command.
    function automatic logic [2:0] beats_f(input logic [7:0] op, input logic [1:0] dl);
        logic [2:0] b;
        b = 3'd0;
        if (op == WRITE_MEM) begin
            unique case (dl)
                DL_128B: b = 3'd2;
                DL_256B: b = 3'd4;
                default: b = 3'd1;
            endcase
        end else if (op == WRITE_MEM_BE) begin
            b = 3'd1;
        end
        return b;
    endfunction

    // A write_mem carrying the reserved length encoding.
    function automatic logic dl_err_f(input logic [7:0] op, input logic [1:0] dl);
        return (op == WRITE_MEM) && (dl == DL_RSVD);
    endfunction

endpackage

// File: rtl/afu_tlx_credit_ctr.sv
// Saturating TLX credit counter: load, return, consume and sticky overflow error.
// Consumption never exceeds the current count; the arbiter only spends what it holds.
module afu_tlx_credit_ctr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         ret_i,
    input  logic [W-1:0] use_i,
    output logic [W-1:0] cnt_o,
    output logic         err_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;
    logic [W:0]   sum;

    // Net return and consumption; an overflow holds the maximum and flags it.
    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(ret_i) - {1'b0, use_i};
        cnt_d = cnt_q;
        err_d = err_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (sum[W]) begin
            cnt_d = '1;
            err_d = 1'b1;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/afu_tlx_cmd_arbiter.sv
// Round-robin arbiter sharing the TLX command/cdata port among AFU engines.
// Define AFU_TLX_ARB_STATS_EN to add the stall_cmd_cnt/stall_data_cnt outputs.
module afu_tlx_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int EA_W    = 64
) (
    input  logic                      afu_clock,
    input  logic                      afu_reset,
    input  logic                      tlx_afu_ready,
    input  logic [3:0]                tlx_afu_cmd_initial_credit,
    input  logic [5:0]                tlx_afu_cmd_data_initial_credit,
    input  logic                      tlx_afu_cmd_credit,
    input  logic                      tlx_afu_cmd_data_credit,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][7:0]   req_opcode,
    input  logic [NUM_REQ-1:0][1:0]   req_dl,
    input  logic [NUM_REQ-1:0][EA_W-1:0] req_ea,
    input  logic [NUM_REQ-1:0][15:0]  req_afutag,
    output logic [NUM_REQ-1:0]        req_grant,
    input  logic [NUM_REQ-1:0]        req_data_valid,
    input  logic [NUM_REQ-1:0][511:0] req_data_bus,
    output logic [NUM_REQ-1:0]        req_data_ack,
    output logic                      afu_tlx_cmd_valid,
    output logic [7:0]                afu_tlx_cmd_opcode,
    output logic [67:0]               afu_tlx_cmd_ea_or_obj,
    output logic [15:0]               afu_tlx_cmd_afutag,
    output logic [1:0]                afu_tlx_cmd_dl,
    output logic                      afu_tlx_cdata_valid,
    output logic [511:0]              afu_tlx_cdata_bus,
    output logic                      afu_tlx_cdata_bdi,
`ifdef AFU_TLX_ARB_STATS_EN
    output logic [31:0]               stall_cmd_cnt,
    output logic [31:0]               stall_data_cnt,
`endif
    output logic                      credit_err
);

    import afu_tlx_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [2:0]       left_q, left_d;
    logic             ready_q;
    logic             rise;
    logic             cand_vld;
    logic [IDX_W-1:0] cand;
    logic [2:0]       cand_beats;
    logic             grant_en;
    logic             ack_en;
    logic [3:0]       cmd_cnt;
    logic [5:0]       data_cnt;
    logic             cmd_err, data_err;

    logic             cmd_valid_q;
    logic [7:0]       cmd_opcode_q;
    logic [67:0]      cmd_ea_q;
    logic [15:0]      cmd_afutag_q;
    logic [1:0]       cmd_dl_q;
    logic             cdata_valid_q;
    logic [511:0]     cdata_bus_q;
    logic             dl_err_q;

    assign rise = tlx_afu_ready && !ready_q && (state_q == WAIT_READY);

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        int j;
        cand_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!cand_vld && req_valid[j]) begin
                cand_vld = 1'b1;
                cand     = IDX_W'(j);
            end
        end
    end

    assign cand_beats = beats_f(req_opcode[cand], req_dl[cand]);
    assign grant_en   = (state_q == ARB) && tlx_afu_ready && cand_vld && !afu_reset
                     && (cmd_cnt != 4'd0) && (data_cnt >= {3'b000, cand_beats});
    assign ack_en     = (state_q == DATA) && req_data_valid[owner_q] && !afu_reset;

    afu_tlx_credit_ctr #(.W(4)) u_cmd_ctr (
        .clk_i      (afu_clock),
        .rst_i      (afu_reset),
        .load_i     (rise),
        .load_val_i (tlx_afu_cmd_initial_credit),
        .ret_i      (tlx_afu_cmd_credit),
        .use_i      ({3'b000, grant_en}),
        .cnt_o      (cmd_cnt),
        .err_o      (cmd_err)
    );

    afu_tlx_credit_ctr #(.W(6)) u_data_ctr (
        .clk_i      (afu_clock),
        .rst_i      (afu_reset),
        .load_i     (rise),
        .load_val_i (tlx_afu_cmd_data_initial_credit),
        .ret_i      (tlx_afu_cmd_data_credit),
        .use_i      (grant_en ? {3'b000, cand_beats} : 6'd0),
        .cnt_o      (data_cnt),
        .err_o      (data_err)
    );

    // State register with pointer, owner and beat count.
    always_ff @(posedge afu_clock) begin
        if (afu_reset) begin
            state_q <= WAIT_READY;
            rr_q    <= '0;
            owner_q <= '0;
            left_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            left_q  <= left_d;
            ready_q <= tlx_afu_ready;
        end
    end

    // Next-state: link-up, arbitration and data beat sequencing.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        left_d  = left_q;
        unique case (state_q)
            WAIT_READY: begin
                if (rise) state_d = ARB;
            end
            ARB: begin
                if (!tlx_afu_ready) begin
                    state_d = WAIT_READY;
                end else if (grant_en) begin
                    rr_d = (cand == IDX_W'(NUM_REQ-1)) ? '0 : cand + 1'b1;
                    if (cand_beats != 3'd0) begin
                        state_d = DATA;
                        owner_d = cand;
                        left_d  = cand_beats;
                    end
                end
            end
            DATA: begin
                if (ack_en) begin
                    left_d = left_q - 3'd1;
                    if (left_q == 3'd1)
                        state_d = tlx_afu_ready ? ARB : WAIT_READY;
                end
            end
            default: state_d = WAIT_READY;
        endcase
    end

    // Output decode: one-hot grant and data acknowledge.
    always_comb begin
        req_grant    = '0;
        req_data_ack = '0;
        if (grant_en) req_grant[cand] = 1'b1;
        if (ack_en) req_data_ack[owner_q] = 1'b1;
    end

    // Framer command/cdata registers and reserved-length error.
    always_ff @(posedge afu_clock) begin
        if (afu_reset) begin
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_ea_q      <= '0;
            cmd_afutag_q  <= '0;
            cmd_dl_q      <= '0;
            cdata_valid_q <= 1'b0;
            cdata_bus_q   <= '0;
            dl_err_q      <= 1'b0;
        end else begin
            cmd_valid_q   <= grant_en;
            cdata_valid_q <= ack_en;
            if (grant_en) begin
                cmd_opcode_q <= req_opcode[cand];
                cmd_ea_q     <= 68'(req_ea[cand]);
                cmd_afutag_q <= req_afutag[cand];
                cmd_dl_q     <= req_dl[cand];
                if (dl_err_f(req_opcode[cand], req_dl[cand])) dl_err_q <= 1'b1;
            end
            if (ack_en) cdata_bus_q <= req_data_bus[owner_q];
        end
    end

    assign afu_tlx_cmd_valid     = cmd_valid_q;
    assign afu_tlx_cmd_opcode    = cmd_opcode_q;
    assign afu_tlx_cmd_ea_or_obj = cmd_ea_q;
    assign afu_tlx_cmd_afutag    = cmd_afutag_q;
    assign afu_tlx_cmd_dl        = cmd_dl_q;
    assign afu_tlx_cdata_valid   = cdata_valid_q;
    assign afu_tlx_cdata_bus     = cdata_bus_q;
    assign afu_tlx_cdata_bdi     = 1'b0;
    assign credit_err            = cmd_err | data_err | dl_err_q;

`ifdef AFU_TLX_ARB_STATS_EN
    logic [31:0] stall_cmd_q, stall_data_q;
    logic        arb_cand;

    assign arb_cand = (state_q == ARB) && tlx_afu_ready && cand_vld;

    // Stall counters: blocked on command credits vs. only on data credits.
    always_ff @(posedge afu_clock) begin
        if (afu_reset) begin
            stall_cmd_q  <= '0;
            stall_data_q <= '0;
        end else begin
            if (arb_cand && cmd_cnt == 4'd0)
                stall_cmd_q <= stall_cmd_q + 32'd1;
            if (arb_cand && cmd_cnt != 4'd0 && data_cnt < {3'b000, cand_beats})
                stall_data_q <= stall_data_q + 32'd1;
        end
    end

    assign stall_cmd_cnt  = stall_cmd_q;
    assign stall_data_cnt = stall_data_q;
`endif

endmodule
